// File: rtl/seq_generator.sv
// ============================================================================
// Module   : seq_generator
// Brief    : Serial pattern generator. It sends the pattern MSB first for a
//            programmable number of repetitions, with idle gaps between them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_generator #(
    parameter int               PAT_W    = 4,
    parameter logic [PAT_W-1:0] PAT_DEF  = 4'b0110,
    parameter int               CNT_W    = 4,
    parameter logic             IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pat_sel,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [CNT_W-1:0] gap,
    input  logic             tx_en,
    input  logic             abort,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int                 c_idx_w = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state,   w_state_nxt;
    logic [PAT_W-1:0]   r_pat,     w_pat_nxt;
    logic [CNT_W-1:0]   r_rem,     w_rem_nxt;
    logic [CNT_W-1:0]   r_gap,     w_gap_nxt;
    logic [CNT_W-1:0]   r_gcnt,    w_gcnt_nxt;
    logic [c_idx_w-1:0] r_idx,     w_idx_nxt;
    logic               r_x_out,   w_x_out_nxt;
    logic               r_x_valid, w_x_valid_nxt;
    logic               r_done,    w_done_nxt;
    logic               w_bit;

    assign w_bit = r_pat[c_last - r_idx];

    always_comb begin
        w_state_nxt   = r_state;
        w_pat_nxt     = r_pat;
        w_rem_nxt     = r_rem;
        w_gap_nxt     = r_gap;
        w_gcnt_nxt    = r_gcnt;
        w_idx_nxt     = r_idx;
        w_x_out_nxt   = r_x_out;
        w_x_valid_nxt = r_x_valid;
        w_done_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_x_out_nxt   = IDLE_BIT;
                w_x_valid_nxt = 1'b0;
                // The done cycle still counts as busy, so a start there is dropped.
                if (start && !abort && !r_done) begin
                    w_pat_nxt   = pat_sel ? pattern : PAT_DEF;
                    w_rem_nxt   = repeat_cnt;
                    w_gap_nxt   = gap;
                    w_idx_nxt   = '0;
                    w_gcnt_nxt  = '0;
                    w_state_nxt = (repeat_cnt != '0) ? S_SEND : S_DONE;
                end
            end

            S_SEND: begin
                if (tx_en) begin
                    w_x_out_nxt   = w_bit;
                    w_x_valid_nxt = 1'b1;
                    if (r_idx == c_last) begin
                        w_idx_nxt = '0;
                        w_rem_nxt = r_rem - CNT_W'(1);
                        if (r_rem == CNT_W'(1)) begin
                            w_state_nxt = S_DONE;
                        end else if (r_gap != '0) begin
                            w_gcnt_nxt  = '0;
                            w_state_nxt = S_GAP;
                        end
                    end else begin
                        w_idx_nxt = r_idx + c_idx_w'(1);
                    end
                end
            end

            S_GAP: begin
                if (tx_en) begin
                    w_x_out_nxt   = IDLE_BIT;
                    w_x_valid_nxt = 1'b0;
                    if (r_gcnt == r_gap - CNT_W'(1)) begin
                        w_gcnt_nxt  = '0;
                        w_state_nxt = S_SEND;
                    end else begin
                        w_gcnt_nxt = r_gcnt + CNT_W'(1);
                    end
                end
            end

            S_DONE: begin
                w_x_out_nxt   = IDLE_BIT;
                w_x_valid_nxt = 1'b0;
                w_done_nxt    = 1'b1;
                w_state_nxt   = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides tx_en gating and suppresses the completion pulse.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt   = S_IDLE;
            w_x_out_nxt   = IDLE_BIT;
            w_x_valid_nxt = 1'b0;
            w_done_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pat     <= '0;
            r_rem     <= '0;
            r_gap     <= '0;
            r_gcnt    <= '0;
            r_idx     <= '0;
            r_x_out   <= IDLE_BIT;
            r_x_valid <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pat     <= w_pat_nxt;
            r_rem     <= w_rem_nxt;
            r_gap     <= w_gap_nxt;
            r_gcnt    <= w_gcnt_nxt;
            r_idx     <= w_idx_nxt;
            r_x_out   <= w_x_out_nxt;
            r_x_valid <= w_x_valid_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign x_out   = r_x_out;
    assign x_valid = r_x_valid;
    assign done    = r_done;
    assign busy    = (r_state != S_IDLE) || r_done;

endmodule

`default_nettype wire

// File: tb/tb_seq_generator.sv
// ============================================================================
// Module   : tb_seq_generator
// Brief    : Directed self-checking bench for seq_generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_generator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pat_sel;
    logic [3:0] pattern;
    logic [3:0] repeat_cnt;
    logic [3:0] gap;
    logic       tx_en;
    logic       abort;
    logic       x_out;
    logic       x_valid;
    logic       busy;
    logic       done;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] det_sh   = 4'b0000;
    int         det_hits = 0;

    seq_generator dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pat_sel    (pat_sel),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .gap        (gap),
        .tx_en      (tx_en),
        .abort      (abort),
        .x_out      (x_out),
        .x_valid    (x_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock, then compare {x_out, x_valid, done}; valid bits feed a 0110 detector.
    task automatic step_chk(input string tag, input logic xo, input logic xv, input logic dn);
        tick();
        check_val(tag, {29'b0, x_out, x_valid, done}, {29'b0, xo, xv, dn});
        if (x_valid) begin
            det_sh = {det_sh[2:0], x_out};
            if (det_sh == 4'b0110) det_hits++;
        end
    endtask

    task automatic launch(input logic sel, input logic [3:0] pat, input logic [3:0] rep,
                          input logic [3:0] gp);
        pat_sel    = sel;
        pattern    = pat;
        repeat_cnt = rep;
        gap        = gp;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        logic [3:0] pd;
        logic [3:0] pb;
        logic [3:0] tx_seq;
        int         vcnt;
        int         cyc;
        logic       seen_done;

        pd = 4'b0110;
        pb = 4'b1011;
        rst = 1'b1; start = 1'b0; pat_sel = 1'b0; pattern = 4'h0;
        repeat_cnt = 4'h0; gap = 4'h0; tx_en = 1'b1; abort = 1'b0;
        tick();
        check_val("rst_x_out",   {31'b0, x_out},   32'd1);
        check_val("rst_x_valid", {31'b0, x_valid}, 32'd0);
        check_val("rst_busy",    {31'b0, busy},    32'd0);
        check_val("rst_done",    {31'b0, done},    32'd0);
        rst = 1'b0;
        tick();

        // Single repetition of the default pattern
        launch(1'b0, 4'h0, 4'd1, 4'd0);
        check_val("r1_busy", {31'b0, busy}, 32'd1);
        for (int i = 3; i >= 0; i--) step_chk($sformatf("r1_bit%0d", 3 - i), pd[i], 1'b1, 1'b0);
        step_chk("r1_done", 1'b1, 1'b0, 1'b1);
        check_val("r1_busy_done", {31'b0, busy}, 32'd1);
        step_chk("r1_after", 1'b1, 1'b0, 1'b0);
        check_val("r1_busy_low", {31'b0, busy}, 32'd0);

        // Three back-to-back repetitions, no gap
        det_sh = 4'b0000; det_hits = 0;
        launch(1'b0, 4'h0, 4'd3, 4'd0);
        for (int r = 0; r < 3; r++)
            for (int i = 3; i >= 0; i--) step_chk($sformatf("r3_rep%0d_bit%0d", r, 3 - i), pd[i], 1'b1, 1'b0);
        step_chk("r3_done", 1'b1, 1'b0, 1'b1);
        check_val("r3_detect", det_hits, 32'd3);
        tick();

        // User pattern, two repetitions separated by a 2-bit gap
        launch(1'b1, 4'b1011, 4'd2, 4'd2);
        for (int i = 3; i >= 0; i--) step_chk($sformatf("g2_a_bit%0d", 3 - i), pb[i], 1'b1, 1'b0);
        step_chk("g2_gap0", 1'b1, 1'b0, 1'b0);
        step_chk("g2_gap1", 1'b1, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) step_chk($sformatf("g2_b_bit%0d", 3 - i), pb[i], 1'b1, 1'b0);
        step_chk("g2_done", 1'b1, 1'b0, 1'b1);
        tick();

        // tx_en alternating: every bit held for one extra cycle, done not gated
        launch(1'b0, 4'h0, 4'd1, 4'd0);
        tx_seq = 4'b0000;
        for (int i = 3; i >= 0; i--) begin
            tx_en = 1'b1;
            step_chk($sformatf("txen_on%0d", 3 - i), pd[i], 1'b1, 1'b0);
            tx_en = 1'b0;
            if (i != 0) step_chk($sformatf("txen_hold%0d", 3 - i), pd[i], 1'b1, 1'b0);
        end
        step_chk("txen_done", 1'b1, 1'b0, 1'b1);
        tx_en = 1'b1;
        tick();

        // Start while busy is ignored; abort after bit 2 returns to idle without done
        launch(1'b0, 4'h0, 4'd2, 4'd0);
        step_chk("ab_bit0", pd[3], 1'b1, 1'b0);
        pat_sel = 1'b1; pattern = 4'b0000; repeat_cnt = 4'd1; start = 1'b1;
        step_chk("ab_bit1", pd[2], 1'b1, 1'b0);
        start = 1'b0;
        step_chk("ab_bit2", pd[1], 1'b1, 1'b0);
        abort = 1'b1;
        step_chk("ab_idle", 1'b1, 1'b0, 1'b0);
        abort = 1'b0;
        check_val("ab_busy", {31'b0, busy}, 32'd0);
        step_chk("ab_nodone0", 1'b1, 1'b0, 1'b0);
        step_chk("ab_nodone1", 1'b1, 1'b0, 1'b0);

        // Start and abort together in idle: start dropped
        abort = 1'b1;
        launch(1'b0, 4'h0, 4'd1, 4'd0);
        abort = 1'b0;
        check_val("sa_busy", {31'b0, busy}, 32'd0);
        step_chk("sa_idle", 1'b1, 1'b0, 1'b0);

        // Zero repetitions: done one cycle after start, no valid bits
        launch(1'b0, 4'h0, 4'd0, 4'd0);
        check_val("z_busy", {31'b0, busy}, 32'd1);
        check_val("z_out", {30'b0, x_out, x_valid}, 32'd2);
        step_chk("z_done", 1'b1, 1'b0, 1'b1);
        step_chk("z_after", 1'b1, 1'b0, 1'b0);
        check_val("z_busy_low", {31'b0, busy}, 32'd0);

        // Maximum repeat count: exactly 15 repetitions, 60 valid bits
        launch(1'b0, 4'h0, 4'd15, 4'd0);
        vcnt = 0; cyc = 0; seen_done = 1'b0;
        while (!seen_done && cyc < 200) begin
            tick();
            cyc++;
            if (x_valid) vcnt++;
            if (done) seen_done = 1'b1;
        end
        check_val("max_done_seen", {31'b0, seen_done}, 32'd1);
        check_val("max_valid_bits", vcnt, 32'd60);
        check_val("max_cycles", cyc, 32'd61);
        tick();

        // Asynchronous reset mid-frame
        launch(1'b0, 4'h0, 4'd1, 4'd0);
        step_chk("rs_bit0", pd[3], 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_val("rs_async", {29'b0, x_out, x_valid, busy}, 32'd4);
        tick();
        rst = 1'b0;
        step_chk("rs_idle0", 1'b1, 1'b0, 1'b0);
        step_chk("rs_idle1", 1'b1, 1'b0, 1'b0);
        check_val("rs_busy", {31'b0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_generator.md
SEQ_GENERATOR -- requirements
Module: seq_generator

Interface
REQ-001 Parameter PAT_W, default 4, pattern length in bits (2..16).
REQ-002 Parameter PAT_DEF, default 4'b0110, pattern loaded when pat_sel=0.
REQ-003 Parameter CNT_W, default 4, width of the repeat and gap counts.
REQ-004 Parameter IDLE_BIT, default 1'b1, line level driven when not transmitting.
REQ-005 clk  in  1  clock; all logic is rising-edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  request a transmission; sampled only in IDLE.
REQ-008 pat_sel  in  1  0 selects PAT_DEF, 1 selects pattern; sampled with start.
REQ-009 pattern  in  PAT_W  user pattern, sent MSB first.
REQ-010 repeat_cnt  in  CNT_W  number of pattern repetitions; 0 means none.
REQ-011 gap  in  CNT_W  idle bit-times inserted between repetitions.
REQ-012 tx_en  in  1  bit-time enable; when 0, the FSM and counters hold.
REQ-013 abort  in  1  synchronous cancel of the current transmission.
REQ-014 x_out  out  1  serial data; registered.
REQ-015 x_valid  out  1  high while x_out carries a pattern bit; registered.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse on normal completion.

Function
REQ-018 The FSM SHALL have the states IDLE, SEND, GAP and DONE.
REQ-019 In IDLE, start=1 SHALL latch the pattern (selected by pat_sel), repeat_cnt and gap.
REQ-019a IDLE->SEND SHALL occur if the latched repeat_cnt>0; IDLE->DONE SHALL occur if repeat_cnt=0.
REQ-020 Start in IDLE SHALL be accepted regardless of tx_en; the first bit SHALL appear on x_out in the first cycle after acceptance in which tx_en=1.
REQ-021 In SEND, each tx_en=1 cycle SHALL drive the next bit, MSB first, on x_out with x_valid=1, using a bit index 0..PAT_W-1.
REQ-022 After bit PAT_W-1 the remaining count SHALL decrement.
REQ-022a If remaining>0 and gap>0, the FSM SHALL go to GAP.
REQ-022b If remaining>0 and gap=0, the FSM SHALL stay in SEND and the next repetition SHALL follow with no bubble.
REQ-022c If remaining=0, the FSM SHALL go to DONE.
REQ-023 GAP SHALL drive x_out=IDLE_BIT and x_valid=0 for exactly gap tx_en=1 cycles, then return to SEND at bit 0.
REQ-024 DONE SHALL assert done for one cycle, drive x_out=IDLE_BIT and x_valid=0, and go to IDLE unconditionally; tx_en SHALL NOT gate DONE.
REQ-025 When tx_en=0 in SEND or GAP, x_out, x_valid, the bit index and the counters SHALL hold their values.
REQ-026 abort=1 in any state other than IDLE SHALL force IDLE on the next edge with x_out=IDLE_BIT, x_valid=0 and no done pulse; abort SHALL take priority over tx_en and completion.
REQ-027 Start while busy=1 SHALL be ignored, and input changes while busy SHALL have no effect.
REQ-028 Start and abort both high in IDLE: abort SHALL win and start SHALL be dropped.
REQ-029 Counters SHALL be CNT_W bits wide and SHALL never wrap; repeat_cnt=2^CNT_W-1 SHALL send exactly that many repetitions.
REQ-030 done SHALL be asserted one cycle after the last pattern bit is driven.
REQ-030a busy SHALL fall in the cycle after done.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, x_out=IDLE_BIT, x_valid=0, busy=0, done=0, and clear all counters and the latched pattern.
REQ-032 rst asserted mid-transmission SHALL abandon the frame without a done pulse; after release, the block SHALL need a new start.

Verification
REQ-033 pat_sel=0, repeat_cnt=1, gap=0, tx_en=1 -> x_out=0,1,1,0 with x_valid=1 for 4 cycles, done on the 5th cycle, then x_out=1.
REQ-034 repeat_cnt=3, gap=0 -> 12 contiguous valid bits 0110_0110_0110; a 0110 overlapping detector on x_out fires 3 times.
REQ-035 pattern=4'b1011, pat_sel=1, repeat_cnt=2, gap=2 -> 1,0,1,1, then 2 idle bits (x_out=1, x_valid=0), then 1,0,1,1, then done.
REQ-036 tx_en toggling 1,0,1,0 during SEND -> each bit is held while tx_en=0, the bit sequence is unchanged, and done is delayed accordingly.
REQ-037 abort after bit 2 of repetition 1 -> IDLE the next cycle, no done; a start issued while busy is ignored.
REQ-038 repeat_cnt=0 -> no valid bits, done one cycle after start; rst pulsed mid-SEND -> outputs reset asynchronously and no done.
